// File: rtl/go_link_pkg.sv
// go_link_pkg: shared framing constants and state encodings for the move link.
// Rev 1.0
`default_nettype none

package go_link_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'h47;
    localparam logic [7:0] PASS_MOVE = 8'hFF;

    typedef enum logic [3:0] {
        PKT_HDR   = 4'b0001,
        PKT_MOVE  = 4'b0010,
        PKT_CHECK = 4'b0100,
        PKT_EMIT  = 4'b1000
    } pkt_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    // A move is legal if the check byte is its complement and it is a pass or on-board.
    function automatic logic move_ok(input logic [7:0] m, input logic [7:0] c);
        return (c == ~m) && ((m == PASS_MOVE) || ((m[7:4] <= 4'd8) && (m[3:0] <= 4'd8)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronizes rx_in and samples 8N1 bytes at mid-bit.
// Rev 1.0
`default_nettype none

module uart_rx_byte
    import go_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic            sync1, sync2, rx_prev;
    rx_state_t       st, st_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [2:0]      bit_idx, bit_nx;
    logic [7:0]      shreg, sh_nx;
    logic            valid_nx, ferr_nx;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx_in;
            sync2      <= sync1;
            rx_prev    <= sync2;
            st         <= st_nx;
            cnt        <= cnt_nx;
            bit_idx    <= bit_nx;
            shreg      <= sh_nx;
            byte_valid <= valid_nx;
            frame_err  <= ferr_nx;
        end
    end

    always_comb begin
        st_nx    = st;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        case (st)
            RX_IDLE: begin
                if (rx_prev && !sync2) begin
                    st_nx  = RX_START;
                    cnt_nx = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    bit_nx = '0;
                    // Line back high at mid start bit means it was only a glitch.
                    st_nx  = sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    sh_nx  = {sync2, shreg[7:1]};
                    if (bit_idx == 3'd7) st_nx = RX_STOP;
                    else                 bit_nx = bit_idx + 3'd1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (sync2) begin
                        valid_nx = 1'b1;
                        st_nx    = RX_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        st_nx    = RX_WAIT;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RX_WAIT: begin
                if (sync2) st_nx = RX_IDLE;
            end
            default: st_nx = RX_IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

`default_nettype wire

// File: rtl/move_link_rx.sv
// move_link_rx: decodes 3-byte move packets from the opponent board with timeout.
// Rev 1.0
`default_nettype none

module move_link_rx
    import go_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       listen_en,
    output logic [7:0] move,
    output logic       move_avail,
    output logic       link_err,
    output logic [3:0] state
);

    localparam int TERM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW   = $clog2(TERM) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TERM - 1);

    logic [7:0]    rx_byte;
    logic          byte_valid, frame_err;
    pkt_state_t    pst, pst_nx;
    logic [7:0]    m_reg, m_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          err_nx, timeout, in_pkt;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_in     (clk_in),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign in_pkt  = (pst == PKT_MOVE) || (pst == PKT_CHECK);
    assign timeout = (tcnt == TO_LAST);

    always_comb begin
        pst_nx  = pst;
        m_nx    = m_reg;
        err_nx  = frame_err;
        tcnt_nx = tcnt;
        if (byte_valid || !in_pkt) tcnt_nx = '0;
        else if (!timeout)         tcnt_nx = tcnt + TW'(1);
        // A byte arriving on the expiry cycle wins over the timeout.
        case (pst)
            PKT_HDR: begin
                if (byte_valid && rx_byte == HDR_BYTE) pst_nx = PKT_MOVE;
            end
            PKT_MOVE: begin
                if (byte_valid) begin
                    m_nx   = rx_byte;
                    pst_nx = PKT_CHECK;
                end else if (timeout) begin
                    pst_nx = PKT_HDR;
                    err_nx = 1'b1;
                end
            end
            PKT_CHECK: begin
                if (byte_valid) begin
                    if (move_ok(m_reg, rx_byte)) begin
                        pst_nx = PKT_EMIT;
                    end else begin
                        pst_nx = PKT_HDR;
                        err_nx = 1'b1;
                    end
                end else if (timeout) begin
                    pst_nx = PKT_HDR;
                    err_nx = 1'b1;
                end
            end
            PKT_EMIT: pst_nx = PKT_HDR;
            default:  pst_nx = PKT_HDR;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            pst        <= PKT_HDR;
            m_reg      <= '0;
            tcnt       <= '0;
            move       <= PASS_MOVE;
            move_avail <= 1'b0;
            link_err   <= 1'b0;
        end else begin
            pst        <= pst_nx;
            m_reg      <= m_nx;
            tcnt       <= tcnt_nx;
            link_err   <= err_nx;
            move_avail <= (pst == PKT_EMIT) && listen_en;
            if ((pst == PKT_EMIT) && listen_en) move <= m_reg;
        end
    end

    assign state = pst;

endmodule

`default_nettype wire

// File: doc/move_link_rx.md
MOVE_LINK_RX -- requirements
Module: move_link_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk_in cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 40, maximum inter-byte gap within a packet, in bit times.
REQ-003 SHALL have port clk_in  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_in  input  1  asynchronous serial line from the opponent board; idle high.
REQ-006 SHALL have port listen_en  input  1  high while the opponent is to move (turn != my_color).
REQ-007 SHALL have port move  output  8  last accepted move: [7:4] row 0-8, [3:0] column 0-8, 8'hFF = pass.
REQ-008 SHALL have port move_avail  output  1  one-cycle pulse qualifying move; drives game_fsm move_avail.
REQ-009 SHALL have port link_err  output  1  one-cycle pulse on any rejected byte or packet.
REQ-010 SHALL have port state  output  4  one-hot packet-FSM state, for debug.

Function
REQ-011 SHALL pass rx_in through a two-flop synchronizer before any use; all decoding uses the synchronized signal.
REQ-012 SHALL detect a start bit on a synchronized high-to-low transition while the byte receiver is idle.
REQ-013 SHALL re-sample at CLKS_PER_BIT/2 after the edge; a high there is a glitch: abandon the byte with no link_err.
REQ-014 SHALL then sample 8 data bits, LSB first, one every CLKS_PER_BIT cycles, then the stop bit.
REQ-015 SHALL deliver the byte with a one-cycle byte_valid if the stop bit is high; if low, drop the byte, pulse link_err, and wait for rx high before re-arming.
REQ-016 SHALL frame packets as 3 bytes: header 8'h47, move byte M, check byte C.
REQ-017 SHALL accept a packet only if C == ~M and M is 8'hFF or both nibbles are <= 8.
REQ-018 Packet FSM states: HDR, MOVE, CHECK, EMIT; reset state HDR.
REQ-019 HDR: a byte of 8'h47 -> MOVE; any other byte is discarded silently and the FSM stays in HDR.
REQ-020 MOVE: any byte is latched as M -> CHECK.
REQ-021 CHECK: byte passes REQ-017 -> EMIT; fails -> HDR with link_err pulse.
REQ-022 EMIT lasts one cycle: if listen_en is high, update move and pulse move_avail, else discard the packet silently; then -> HDR.
REQ-023 move SHALL change only in EMIT with listen_en high and SHALL otherwise hold its value.
REQ-024 In MOVE or CHECK, SHALL count clk_in cycles since the last byte_valid; at TIMEOUT_BITS*CLKS_PER_BIT -> HDR with link_err pulse.
REQ-025 A byte_valid in the same cycle as timeout expiry SHALL take priority; the timeout is ignored.
REQ-026 Latency: move_avail SHALL assert exactly 2 cycles after the byte_valid of the check byte.
REQ-027 Counters SHALL be $clog2 of their terminal count plus 1 bit wide and SHALL NOT wrap.

Reset
REQ-028 Reset SHALL set move=8'hFF, move_avail=0, link_err=0, state=HDR (4'b0001), byte receiver idle, all counters 0, synchronizer flops 1.
REQ-029 Reset asserted mid-byte or mid-packet SHALL discard all partial data; reception restarts at the next start edge after reset is released.

Structure
REQ-030 Header value, pass code 8'hFF, and the one-hot state encodings SHALL live in the shared go_link_pkg package; the transmitter uses the same definitions.
REQ-031 The bit-level receiver SHALL be one sub-module, uart_rx_byte (synchronizer + start/data/stop sampling, byte/byte_valid/frame_err outputs); packet FSM and timeout stay in move_link_rx.

Verification
REQ-032 Bench SHALL run with CLKS_PER_BIT=4 and TIMEOUT_BITS=40 and cover the scenarios REQ-033 to REQ-038.
REQ-033 Valid placement: listen_en=1; send 47,34,CB -> one move_avail pulse, move=8'h34, link_err never high.
REQ-034 Pass packet: send 47,FF,00 -> move_avail pulse, move=8'hFF.
REQ-035 Bad check byte: send 47,34,CC -> link_err pulse, no move_avail, move unchanged.
REQ-036 Out-of-range move: send 47,9A,65 -> link_err pulse, no move_avail; a following 47,00,FF -> move=8'h00.
REQ-037 Stop-bit error and glitch: stop bit low on the header -> link_err and resync; a 1-cycle low glitch on idle rx_in -> no byte, no error.
REQ-038 Timeout and reset: send 47 then 200 idle cycles -> link_err at 160 cycles; reset mid-packet -> outputs at reset values, next clean packet accepted; listen_en=0 with a valid packet -> no move_avail.
